// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package hazard_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_HOLD = 2'd1,
      FLUSH    = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO       = 5'd0;
   localparam int         MDU_CYCLES_DEF = 4;
   localparam int         CNT_W_DEF      = 4;
endpackage

// File: rtl/hazard_stall_ctrl_mdu_hold_timer.sv
// Down-counter tracking the remaining EX hold cycles of a multi-cycle HI/LO op.
module mdu_hold_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             abort,
   input  logic [CNT_W-1:0] load_val,
   output logic             done,
   output logic             busy
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;

   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (abort) begin
         cnt_d  = '0;
         busy_d = 1'b0;
      end else if (load) begin
         cnt_d  = load_val;
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Stop at zero rather than wrapping; the final cycle just drops busy.
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign done = busy_q && (cnt_q == '0);
   assign busy = busy_q;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, MDU holds, branch squash.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_CYCLES = MDU_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_write_reg,
   input  logic       ex_hilo_op,
   input  logic       mem_branch,
   input  logic       mem_zero,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       id_ex_write,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_mem_flush,
   output logic       pc_src,
   output logic       mdu_busy,
   output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_load_stalls,
   output logic [31:0] perf_mdu_stalls,
   output logic [31:0] perf_flushes
`endif
);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MDU_CYCLES - 2);

   state_e state_q, state_d;
   logic   br_taken, load_use;
   logic   tmr_load, tmr_abort, tmr_done, tmr_busy;
   logic   load_stall_cyc;

   assign br_taken = mem_branch & mem_zero;
   assign load_use = ex_mem_read && (ex_write_reg != REG_ZERO) &&
                     ((id_uses_rs && (id_rs == ex_write_reg)) ||
                      (id_uses_rt && (id_rt == ex_write_reg)));

   always_comb begin
      state_d        = state_q;
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      id_ex_write    = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_flush   = 1'b0;
      pc_src         = 1'b0;
      mdu_busy       = 1'b0;
      tmr_load       = 1'b0;
      tmr_abort      = 1'b0;
      load_stall_cyc = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         tmr_abort    = 1'b1;
         state_d      = RUN;
      end else if (br_taken) begin
         // Wrong-path squash wins over everything, including an active MDU op.
         pc_src       = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         tmr_abort    = 1'b1;
         state_d      = FLUSH;
      end else begin
         unique case (state_q)
            RUN: begin
               if (ex_hilo_op) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_write = 1'b0;
                  mdu_busy    = 1'b1;
                  tmr_load    = 1'b1;
                  state_d     = MDU_HOLD;
               end else if (load_use) begin
                  pc_write       = 1'b0;
                  if_id_write    = 1'b0;
                  id_ex_flush    = 1'b1;
                  load_stall_cyc = 1'b1;
               end
            end
            MDU_HOLD: begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_write  = 1'b0;
               mdu_busy     = tmr_busy;
               ex_mem_flush = !tmr_done;
               if (tmr_done || !tmr_busy) begin
                  state_d = RUN;
               end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

   mdu_hold_timer #(.CNT_W(CNT_W)) u_mdu_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .abort    (tmr_abort),
      .load_val (HOLD_LOAD),
      .done     (tmr_done),
      .busy     (tmr_busy)
   );

`ifdef HAZARD_PERF_CNT_EN
   logic [2:0]  perf_inc;
   logic [31:0] perf_q [3];

   assign perf_inc[0] = load_stall_cyc;
   assign perf_inc[1] = (state_q == MDU_HOLD);
   assign perf_inc[2] = br_taken;

   for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      logic [31:0] perf_d;
      always_comb begin
         perf_d = perf_q[gi];
         if (perf_inc[gi] && (perf_q[gi] != '1)) begin
            perf_d = perf_q[gi] + 32'd1;
         end
      end
      always_ff @(posedge clk) begin
         if (rst) begin
            perf_q[gi] <= '0;
         end else begin
            perf_q[gi] <= perf_d;
         end
      end
   end

   assign perf_load_stalls = perf_q[0];
   assign perf_mdu_stalls  = perf_q[1];
   assign perf_flushes     = perf_q[2];
`else
   logic unused_load_stall;
   assign unused_load_stall = load_stall_cyc;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a randomized
// run against a cycle-level reference model.
module tb_hazard_stall_ctrl;
   localparam int MC = 4;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_write_reg;
   logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_hilo_op, mem_branch, mem_zero;
   logic       pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush;
   logic       ex_mem_flush, pc_src, mdu_busy;
   logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_load_stalls, perf_mdu_stalls, perf_flushes;
`endif
   logic [9:0] obs;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   hazard_stall_ctrl #(.MDU_CYCLES(MC), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .ex_mem_read  (ex_mem_read),
      .ex_write_reg (ex_write_reg),
      .ex_hilo_op   (ex_hilo_op),
      .mem_branch   (mem_branch),
      .mem_zero     (mem_zero),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .id_ex_write  (id_ex_write),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_flush (ex_mem_flush),
      .pc_src       (pc_src),
      .mdu_busy     (mdu_busy),
      .state        (state)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_load_stalls (perf_load_stalls),
      .perf_mdu_stalls  (perf_mdu_stalls),
      .perf_flushes     (perf_flushes)
`endif
   );

   assign obs = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
                 ex_mem_flush, pc_src, mdu_busy, state};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_write_reg = 5'd0; ex_hilo_op = 1'b0;
      mem_branch = 1'b0; mem_zero = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_inputs(); #1;
      chk_cnt++;
      if ({pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush, pc_src, mdu_busy} !== 8'b000_111_00)
         $display("FAIL reset_forced: got %b want %b",
                  {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush, pc_src, mdu_busy}, 8'b000_111_00);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else pass_cnt++;
      rst = 1'b0; #1;
      chk_cnt++;
      if (obs !== 10'b111_000_00_00) $display("FAIL reset_run_idle: got %b want %b", obs, 10'b111_000_00_00);
      else pass_cnt++;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_load_use();
      idle_inputs();
      ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; #1;
      chk_cnt++;
      if ({pc_write, if_id_write, id_ex_flush, state} !== 5'b001_00)
         $display("FAIL load_use_stall: got %b want %b", {pc_write, if_id_write, id_ex_flush, state}, 5'b001_00);
      else pass_cnt++;
      tick();
      ex_mem_read = 1'b0; ex_write_reg = 5'd0; #1;
      chk_cnt++;
      if ({pc_write, if_id_write, id_ex_write, id_ex_flush} !== 4'b1110)
         $display("FAIL load_use_release: got %b want %b", {pc_write, if_id_write, id_ex_write, id_ex_flush}, 4'b1110);
      else pass_cnt++;
      tick();
      $display("test_load_use done");
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      ex_mem_read = 1'b1; ex_write_reg = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
      id_rt = 5'd0; id_uses_rt = 1'b1; #1;
      chk_cnt++;
      if ({pc_write, if_id_write, id_ex_write, id_ex_flush} !== 4'b1110)
         $display("FAIL zero_reg_no_stall: got %b want %b", {pc_write, if_id_write, id_ex_write, id_ex_flush}, 4'b1110);
      else pass_cnt++;
      tick();
      $display("test_zero_reg done");
   endtask

   task automatic test_mdu();
      idle_inputs();
      ex_hilo_op = 1'b1;
      for (int c = 1; c <= MC; c++) begin
         logic exp_emf;
         #1;
         exp_emf = (c != 1) && (c != MC);
         chk_cnt++;
         if ({pc_write, if_id_write, id_ex_write, mdu_busy, ex_mem_flush} !== {4'b0001, exp_emf})
            $display("FAIL mdu_cycle%0d: got %b want %b", c,
                     {pc_write, if_id_write, id_ex_write, mdu_busy, ex_mem_flush}, {4'b0001, exp_emf});
         else pass_cnt++;
         chk_cnt++;
         if (state !== ((c == 1) ? 2'd0 : 2'd1)) $display("FAIL mdu_state%0d: got %0d", c, state);
         else pass_cnt++;
         tick();
      end
      ex_hilo_op = 1'b0; #1;
      chk_cnt++;
      if ({state, pc_write, mdu_busy} !== 4'b0010)
         $display("FAIL mdu_return: got %b want %b", {state, pc_write, mdu_busy}, 4'b0010);
      else pass_cnt++;
      tick();
      $display("test_mdu done");
   endtask

   task automatic test_branch_kill();
      idle_inputs();
      ex_hilo_op = 1'b1;
      tick();
      tick();
      mem_branch = 1'b1; mem_zero = 1'b1; #1;
      chk_cnt++;
      if ({state, pc_src, pc_write, if_id_flush, id_ex_flush, ex_mem_flush} !== 7'b01_11_111)
         $display("FAIL branch_kill_outs: got %b want %b",
                  {state, pc_src, pc_write, if_id_flush, id_ex_flush, ex_mem_flush}, 7'b01_11_111);
      else pass_cnt++;
      tick();
      idle_inputs(); #1;
      chk_cnt++;
      if ({state, mdu_busy, pc_write, if_id_write, id_ex_write, pc_src} !== 7'b10_0_111_0)
         $display("FAIL branch_kill_flush: got %b want %b",
                  {state, mdu_busy, pc_write, if_id_write, id_ex_write, pc_src}, 7'b10_0_111_0);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (state !== 2'd0) $display("FAIL branch_kill_run: got %0d want 0", state); else pass_cnt++;
      $display("test_branch_kill done");
   endtask

   task automatic test_simultaneous();
      idle_inputs();
      ex_mem_read = 1'b1; ex_write_reg = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
      mem_branch = 1'b1; mem_zero = 1'b1; #1;
      chk_cnt++;
      if ({pc_write, if_id_write, pc_src, if_id_flush, id_ex_flush, ex_mem_flush} !== 6'b111111)
         $display("FAIL simult_outs: got %b want %b",
                  {pc_write, if_id_write, pc_src, if_id_flush, id_ex_flush, ex_mem_flush}, 6'b111111);
      else pass_cnt++;
      tick();
      idle_inputs(); #1;
      chk_cnt++;
      if (state !== 2'd2) $display("FAIL simult_flush_state: got %0d want 2", state); else pass_cnt++;
      tick();
      $display("test_simultaneous done");
   endtask

   task automatic test_reset_mid_op();
      idle_inputs();
      ex_hilo_op = 1'b1;
      tick();
      rst = 1'b1; #1;
      chk_cnt++;
      if ({state, pc_write, mdu_busy, ex_mem_flush} !== 5'b01_0_0_1)
         $display("FAIL rst_mid_forced: got %b want %b", {state, pc_write, mdu_busy, ex_mem_flush}, 5'b01_0_0_1);
      else pass_cnt++;
      tick();
      rst = 1'b0; ex_hilo_op = 1'b0; #1;
      chk_cnt++;
      if ({state, mdu_busy, pc_write} !== 4'b00_0_1)
         $display("FAIL rst_mid_after: got %b want %b", {state, mdu_busy, pc_write}, 4'b00_0_1);
      else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
      chk_cnt++;
      if ({perf_load_stalls, perf_mdu_stalls, perf_flushes} !== 96'd0)
         $display("FAIL rst_mid_perf: got %0d %0d %0d want 0 0 0", perf_load_stalls, perf_mdu_stalls, perf_flushes);
      else pass_cnt++;
`endif
      tick();
      $display("test_reset_mid_op done");
   endtask

   // Reference model: mode 0 running, 1 holding for a pending HI/LO op, 2 recovering
   // from a squash; hold_left counts the hold cycles still owed to the MDU op.
   task automatic test_random(input int n);
      int   mode, hold_left, errs;
      bit   br, lu;
      logic e_pcw, e_ifw, e_idw, e_iff, e_idf, e_emf, e_src, e_busy;
      logic [9:0] exp_v;
      int   m_pl, m_pm, m_pf;
      rst = 1'b1; idle_inputs(); tick(); rst = 1'b0;
      mode = 0; hold_left = 0; errs = 0; m_pl = 0; m_pm = 0; m_pf = 0;
      for (int i = 0; i < n; i++) begin
         rst          = ($urandom_range(0, 59) == 0);
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         id_uses_rs   = 1'($urandom_range(0, 1));
         id_uses_rt   = 1'($urandom_range(0, 1));
         ex_mem_read  = 1'($urandom_range(0, 1));
         ex_write_reg = 5'($urandom_range(0, 3));
         ex_hilo_op   = ($urandom_range(0, 5) == 0);
         mem_branch   = ($urandom_range(0, 5) == 0);
         mem_zero     = 1'($urandom_range(0, 1));
         #1;
         br = mem_branch && mem_zero;
         lu = ex_mem_read && (ex_write_reg != 0) &&
              ((id_uses_rs && id_rs == ex_write_reg) || (id_uses_rt && id_rt == ex_write_reg));
         {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_emf, e_src, e_busy} = 8'b111_000_00;
         if (rst) begin
            {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_emf} = 6'b000_111;
         end else if (br) begin
            {e_iff, e_idf, e_emf, e_src} = 4'b1111;
         end else if (mode == 1) begin
            {e_pcw, e_ifw, e_idw, e_busy} = 4'b0001;
            e_emf = (hold_left > 1);
         end else if (mode == 0 && ex_hilo_op) begin
            {e_pcw, e_ifw, e_idw, e_busy} = 4'b0001;
         end else if (mode == 0 && lu) begin
            {e_pcw, e_ifw, e_idf} = 3'b001;
         end
         exp_v = {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_emf, e_src, e_busy, 2'(mode)};
         chk_cnt++;
         if (obs !== exp_v) begin
            $display("FAIL random_cycle%0d: got %b want %b", i, obs, exp_v);
            errs++;
         end else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
         chk_cnt++;
         if (perf_load_stalls !== 32'(m_pl) || perf_mdu_stalls !== 32'(m_pm) || perf_flushes !== 32'(m_pf)) begin
            $display("FAIL random_perf%0d: got %0d %0d %0d want %0d %0d %0d", i,
                     perf_load_stalls, perf_mdu_stalls, perf_flushes, m_pl, m_pm, m_pf);
            errs++;
         end else pass_cnt++;
`endif
         tick();
         if (rst) begin
            m_pl = 0; m_pm = 0; m_pf = 0;
         end else begin
            if (br) m_pf++;
            if (mode == 1) m_pm++;
            if (!br && mode == 0 && !ex_hilo_op && lu) m_pl++;
         end
         if (rst) begin
            mode = 0; hold_left = 0;
         end else if (br) begin
            mode = 2; hold_left = 0;
         end else if (mode == 1) begin
            hold_left--;
            if (hold_left == 0) mode = 0;
         end else if (mode == 2) begin
            mode = 0;
         end else if (ex_hilo_op) begin
            mode = 1; hold_left = MC - 1;
         end
      end
      rst = 1'b0;
      $display("test_random done: %0d cycles, %0d errors", n, errs);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_zero_reg();
      test_mdu();
      test_branch_kill();
      test_simultaneous();
      test_reset_mid_op();
      test_random(400);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
